s832_response_misr: RTL and testbench

//  Downstream capture stage for the s832 core. Compacts the 19 s832 primary outputs into a
//  19-bit MISR signature over a fixed number of valid patterns, then compares it to a golden value.

---
 rtl/s832_response_misr_pkg.sv | 6 +
 rtl/s832_response_misr_if.sv | 14 +
 rtl/s832_response_misr_misr_reg.sv | 18 +
 rtl/s832_response_misr.sv | 57 +++++
 tb/tb_s832_response_misr.sv | 128 ++++++++++++
 5 files changed

// File: rtl/s832_response_misr_pkg.sv
// s832_tb_pkg: shared widths, feedback polynomial and FSM state type for the s832 response MISR
package s832_tb_pkg;
  localparam int S832_RESP_W = 19;
  localparam logic [S832_RESP_W-1:0] S832_MISR_POLY = 19'h00027;
  typedef enum logic [1:0] {IDLE, RUN, DONE} misr_state_t;
endpackage

// File: rtl/s832_response_misr_if.sv
// s832_response_misr_if: control, response and result signals between test control and the MISR
interface s832_response_misr_if #(parameter int RESP_W = 19, parameter int CNT_W = 16);
  logic start;
  logic abort;
  logic resp_valid;
  logic [RESP_W-1:0] resp;
  logic busy;
  logic done;
  logic pass;
  logic [RESP_W-1:0] signature;
  logic [CNT_W-1:0] count;
  modport master(output start, abort, resp_valid, resp, input busy, done, pass, signature, count);
  modport slave(input start, abort, resp_valid, resp, output busy, done, pass, signature, count);
endinterface

// File: rtl/s832_response_misr_misr_reg.sv
// misr_reg: signature register with clear-to-seed and one MISR step per enabled cycle
module misr_reg #(
  parameter int WIDTH = 19,
  parameter logic [WIDTH-1:0] POLY = '0,
  parameter logic [WIDTH-1:0] SEED = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic step,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nxt
);
  assign nxt = {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? POLY : '0) ^ d;
  always_ff @(posedge clk)
    q <= (rst || clr) ? SEED : step ? nxt : q;
endmodule

// File: rtl/s832_response_misr.sv
// s832_response_misr: compacts s832 responses into a MISR signature and compares it to a golden value
module s832_response_misr
  import s832_tb_pkg::*;
#(
  parameter int RESP_W = S832_RESP_W,
  parameter logic [RESP_W-1:0] POLY = S832_MISR_POLY,
  parameter logic [RESP_W-1:0] SEED = '0,
  parameter logic [RESP_W-1:0] GOLDEN = '0,
  parameter int PATTERNS = 1024,
  parameter int CNT_W = 16
) (
  input logic ck,
  input logic rst,
  s832_response_misr_if.slave bus
);
  if (PATTERNS < 1 || PATTERNS > 2 ** CNT_W) begin : g_chk
    $error("PATTERNS must be in 1..2**CNT_W");
  end
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PATTERNS - 1);
  misr_state_t state;
  logic clr, step;
  logic [RESP_W-1:0] nxt;
  always_comb begin
    clr = state != RUN && bus.start && !bus.abort;
    step = state == RUN && bus.resp_valid && !bus.abort;
  end
  misr_reg #(.WIDTH(RESP_W), .POLY(POLY), .SEED(SEED)) u_misr (
    .clk(ck), .rst(rst), .clr(clr), .step(step), .d(bus.resp), .q(bus.signature), .nxt(nxt)
  );
  always_ff @(posedge ck)
    if (rst) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.pass <= 1'b0;
      bus.count <= '0;
    end else if (bus.abort) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.pass <= 1'b0;
    end else if (clr) begin
      state <= RUN;
      bus.busy <= 1'b1;
      bus.done <= 1'b0;
      bus.pass <= 1'b0;
      bus.count <= '0;
    end else if (step) begin
      bus.count <= bus.count + 1'b1;
      if (bus.count == LAST) begin
        state <= DONE;
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
        bus.pass <= nxt == GOLDEN;
      end
    end
endmodule

// File: tb/tb_s832_response_misr.sv
// tb_s832_response_misr: table-driven vectors with an expected-result scoreboard for two MISR configurations
module tb_s832_response_misr;
  typedef struct {
    int which;
    logic rst, start, abort, valid;
    logic [18:0] resp;
    logic [18:0] sig;
    logic [15:0] cnt;
    logic busy, done, pass;
  } vec_t;
  logic ck = 1'b0;
  logic rst_a, rst_b;
  int checks = 0, failures = 0;
  vec_t tab[$];
  vec_t sb[$];
  always #5 ck = ~ck;
  s832_response_misr_if #(.RESP_W(19), .CNT_W(16)) ia();
  s832_response_misr_if #(.RESP_W(19), .CNT_W(16)) ib();
  s832_response_misr #(.SEED(19'h00000), .GOLDEN(19'h00008), .PATTERNS(4)) dut_a (
    .ck(ck), .rst(rst_a), .bus(ia)
  );
  s832_response_misr #(.SEED(19'h40000), .GOLDEN(19'h00000), .PATTERNS(1)) dut_b (
    .ck(ck), .rst(rst_b), .bus(ib)
  );
  function automatic vec_t mk(int w, logic r, logic s, logic a, logic v, logic [18:0] d,
                              logic [18:0] sg, logic [15:0] c, logic b, logic dn, logic p);
    vec_t x;
    x.which = w; x.rst = r; x.start = s; x.abort = a; x.valid = v; x.resp = d;
    x.sig = sg; x.cnt = c; x.busy = b; x.done = dn; x.pass = p;
    return x;
  endfunction
  task automatic chk(string name, int idx, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, got, want);
    end
  endtask
  task automatic drive(vec_t v);
    rst_a = 1'b0; ia.start = 1'b0; ia.abort = 1'b0; ia.resp_valid = 1'b0; ia.resp = '0;
    rst_b = 1'b0; ib.start = 1'b0; ib.abort = 1'b0; ib.resp_valid = 1'b0; ib.resp = '0;
    if (v.which == 0) begin
      rst_a = v.rst; ia.start = v.start; ia.abort = v.abort; ia.resp_valid = v.valid; ia.resp = v.resp;
    end else begin
      rst_b = v.rst; ib.start = v.start; ib.abort = v.abort; ib.resp_valid = v.valid; ib.resp = v.resp;
    end
    sb.push_back(v);
  endtask
  task automatic observe(int idx);
    vec_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", idx, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    if (e.which == 0) begin
      chk("sig_a", idx, 32'(ia.signature), 32'(e.sig));
      chk("cnt_a", idx, 32'(ia.count), 32'(e.cnt));
      chk("busy_a", idx, 32'(ia.busy), 32'(e.busy));
      chk("done_a", idx, 32'(ia.done), 32'(e.done));
      chk("pass_a", idx, 32'(ia.pass), 32'(e.pass));
    end else begin
      chk("sig_b", idx, 32'(ib.signature), 32'(e.sig));
      chk("cnt_b", idx, 32'(ib.count), 32'(e.cnt));
      chk("busy_b", idx, 32'(ib.busy), 32'(e.busy));
      chk("done_b", idx, 32'(ib.done), 32'(e.done));
      chk("pass_b", idx, 32'(ib.pass), 32'(e.pass));
    end
  endtask
  initial begin
    // w  rst st ab v  resp      sig       cnt  busy done pass
    tab.push_back(mk(0, 1, 0, 0, 0, 19'h0, 19'h00000, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 19'h0, 19'h00000, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 1, 0, 1, 19'h5, 19'h00000, 0, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 19'h1, 19'h00001, 1, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 19'h0, 19'h00002, 2, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 19'h0, 19'h00004, 3, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 19'h0, 19'h00008, 4, 0, 1, 1));
    tab.push_back(mk(0, 0, 0, 0, 1, 19'h7, 19'h00008, 4, 0, 1, 1));
    tab.push_back(mk(0, 0, 1, 0, 1, 19'h3, 19'h00000, 0, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 19'h1, 19'h00001, 1, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 19'h0, 19'h00002, 2, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      tab.push_back(mk(0, 0, 0, 0, 0, 19'h1f, 19'h00002, 2, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 19'h0, 19'h00004, 3, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 19'h0, 19'h00008, 4, 0, 1, 1));
    tab.push_back(mk(0, 0, 1, 0, 0, 19'h0, 19'h00000, 0, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 19'h1, 19'h00001, 1, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 19'h0, 19'h00002, 2, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 19'h0, 19'h00004, 3, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 1, 1, 19'h0, 19'h00004, 3, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 19'h9, 19'h00004, 3, 0, 0, 0));
    tab.push_back(mk(0, 0, 1, 0, 0, 19'h0, 19'h00000, 0, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 19'h1, 19'h00001, 1, 1, 0, 0));
    tab.push_back(mk(0, 0, 1, 0, 0, 19'h0, 19'h00001, 1, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 19'h0, 19'h00002, 2, 1, 0, 0));
    tab.push_back(mk(0, 1, 1, 0, 1, 19'h1, 19'h00000, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 19'h1, 19'h00000, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 1, 0, 0, 19'h0, 19'h00000, 0, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 19'h1, 19'h00001, 1, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 19'h2, 19'h00000, 2, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 19'h3, 19'h00003, 3, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 19'h4, 19'h00002, 4, 0, 1, 0));
    tab.push_back(mk(0, 0, 0, 1, 0, 19'h0, 19'h00002, 4, 0, 0, 0));
    tab.push_back(mk(0, 0, 1, 1, 0, 19'h0, 19'h00002, 4, 0, 0, 0));
    tab.push_back(mk(1, 1, 0, 0, 0, 19'h0, 19'h40000, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, 1, 0, 0, 19'h0, 19'h40000, 0, 1, 0, 0));
    tab.push_back(mk(1, 0, 0, 0, 1, 19'h0, 19'h00027, 1, 0, 1, 0));
    tab.push_back(mk(1, 0, 0, 0, 1, 19'h1, 19'h00027, 1, 0, 1, 0));
    tab.push_back(mk(1, 0, 1, 0, 0, 19'h0, 19'h40000, 0, 1, 0, 0));
    tab.push_back(mk(1, 0, 0, 0, 0, 19'h0, 19'h40000, 0, 1, 0, 0));
    tab.push_back(mk(1, 0, 0, 0, 1, 19'h1, 19'h00026, 1, 0, 1, 0));
    rst_a = 1'b1; rst_b = 1'b1;
    ia.start = 1'b0; ia.abort = 1'b0; ia.resp_valid = 1'b0; ia.resp = '0;
    ib.start = 1'b0; ib.abort = 1'b0; ib.resp_valid = 1'b0; ib.resp = '0;
    repeat (2) @(posedge ck);
    #1;
    foreach (tab[i]) begin
      drive(tab[i]);
      @(posedge ck);
      #1;
      observe(i);
    end
    chk("scoreboard_drained", tab.size(), 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
